// File: rtl/dfp_addsub96_sched_pkg.sv
// Shared types for the DFP96 add/sub scheduler: the operand/result type,
// the fixed pipe latency and the response FIFO entry.
package dfp_addsub96_sched_pkg;

  typedef logic [95:0] dfp96_t;

  localparam int DFP_ADDSUB96_LAT = 16;

  // Id field is sized for the largest supported requester count (8).
  typedef struct packed {
    logic [2:0] id;
    dfp96_t     res;
  } dfp_sched_rsp_t;

endpackage

// File: rtl/dfp_sched_rr_arb.sv
// Round-robin arbiter: picks the first requester at or after ptr (wrapping).
// The grant vector is gated by en; the encoded id is always the pick.
module dfp_sched_rr_arb #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  input  logic             en,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   id
);

  // Scan requesters starting from ptr, first valid one wins.
  always_comb begin
    int  idx;
    logic hit;
    grant = '0;
    id    = '0;
    hit   = 1'b0;
    idx   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (!hit && req[idx]) begin
        hit        = 1'b1;
        grant[idx] = en;
        id         = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/dfp_addsub96_sched.sv
// Shares one pipelined DFP96 add/sub unit among N_REQ requesters.
// Round-robin issue, LAT-deep tag pipe tracking in-flight ops, response FIFO,
// and credit-limited issue so the FIFO can never overflow.
// Optional build macro DFP_SCHED_PERF_EN adds perf_issue / perf_stall counters.
module dfp_addsub96_sched
  import dfp_addsub96_sched_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int LAT        = DFP_ADDSUB96_LAT,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ-1:0]         req_op,
  input  logic [N_REQ*3-1:0]       req_rm,
  input  logic [N_REQ*96-1:0]      req_a,
  input  logic [N_REQ*96-1:0]      req_b,
  output logic                     pipe_ce,
  output logic                     pipe_op,
  output logic [2:0]               pipe_rm,
  output logic [95:0]              pipe_a,
  output logic [95:0]              pipe_b,
  input  logic [95:0]              pipe_o,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic [95:0]              rsp_o,
  output logic                     busy
`ifdef DFP_SCHED_PERF_EN
  ,
  output logic [31:0]              perf_issue,
  output logic [31:0]              perf_stall
`endif
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(LAT + 1);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);

  logic [IDW-1:0]          rr_ptr;
  logic [IDW-1:0]          win_id;
  logic [N_REQ-1:0]        grant;
  logic                    credit_ok;
  logic                    hs;

  logic [LAT-1:0]          tag_vld;
  logic [LAT-1:0][IDW-1:0] tag_id;
  logic [CW-1:0]           inflight;

  dfp_sched_rsp_t          mem [FIFO_DEPTH];
  dfp_sched_rsp_t          head;
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [FCW-1:0]          fifo_count;
  logic                    push, pop;

  // Conservative credit: a pop this cycle only frees space next cycle.
  assign credit_ok = (int'(inflight) + int'(fifo_count)) < FIFO_DEPTH;

  dfp_sched_rr_arb #(.N_REQ(N_REQ), .IDW(IDW)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .en    (credit_ok & pipe_ce),
    .grant (grant),
    .id    (win_id)
  );

  assign req_ready = grant;
  assign hs        = |grant;

  assign push      = tag_vld[LAT-1];
  assign rsp_valid = fifo_count != '0;
  assign pop       = rsp_valid & rsp_ready;
  assign head      = mem[rd_ptr];
  assign rsp_id    = IDW'(head.id);
  assign rsp_o     = head.res;
  assign busy      = (inflight != '0) || rsp_valid;

  // Pipe enable, RR pointer and registered operands for the shared pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_ce <= 1'b0;
      rr_ptr  <= '0;
      pipe_op <= 1'b0;
      pipe_rm <= '0;
      pipe_a  <= '0;
      pipe_b  <= '0;
    end else begin
      pipe_ce <= 1'b1;
      if (hs) begin
        rr_ptr  <= (int'(win_id) == N_REQ - 1) ? '0 : win_id + 1'b1;
        pipe_op <= req_op[win_id];
        pipe_rm <= req_rm[win_id*3 +: 3];
        pipe_a  <= req_a[win_id*96 +: 96];
        pipe_b  <= req_b[win_id*96 +: 96];
      end
    end
  end

  // Tag pipe mirrors the shared pipe; the valid bit alone qualifies pipe_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld  <= '0;
      tag_id   <= '0;
      inflight <= '0;
    end else begin
      tag_vld  <= {tag_vld[LAT-2:0], hs};
      tag_id   <= {tag_id[LAT-2:0], win_id};
      inflight <= inflight + CW'(hs) - CW'(push);
    end
  end

  // Response FIFO: push on tag-pipe completion, pop on consumer handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{id: 3'(tag_id[LAT-1]), res: pipe_o};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + FCW'(push) - FCW'(pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && fifo_count == FCW'(FIFO_DEPTH)));

`ifdef DFP_SCHED_PERF_EN
  // Issue and credit-stall counters, free-running with natural 32-bit wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issue <= '0;
      perf_stall <= '0;
    end else begin
      perf_issue <= perf_issue + 32'(hs);
      perf_stall <= perf_stall + 32'((|req_valid) && !credit_ok);
    end
  end
`endif

endmodule

// File: tb/tb_dfp_addsub96_sched.sv
// Directed bench for dfp_addsub96_sched; the pipe is modelled as a
// LAT-cycle delay of f(a,b,op) = op ? a-b : a+b on raw 96-bit values.
module tb_dfp_addsub96_sched;
  import dfp_addsub96_sched_pkg::*;

  localparam int N   = 4;
  localparam int LAT = 16;
  localparam int FD  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid, req_ready, req_op;
  logic [N*3-1:0]    req_rm;
  logic [N*96-1:0]   req_a, req_b;
  logic              pipe_ce, pipe_op;
  logic [2:0]        pipe_rm;
  logic [95:0]       pipe_a, pipe_b, pipe_o;
  logic              rsp_valid, rsp_ready, busy;
  logic [1:0]        rsp_id;
  logic [95:0]       rsp_o;
`ifdef DFP_SCHED_PERF_EN
  logic [31:0]       perf_issue, perf_stall;
`endif

  int checks = 0;
  int errors = 0;
  int      got_id  [$];
  dfp96_t  got_o   [$];

  always #5 clk = ~clk;

  dfp_addsub96_sched #(.N_REQ(N), .LAT(LAT), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rm(req_rm), .req_a(req_a), .req_b(req_b),
    .pipe_ce(pipe_ce), .pipe_op(pipe_op), .pipe_rm(pipe_rm),
    .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_o(pipe_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_o(rsp_o), .busy(busy)
`ifdef DFP_SCHED_PERF_EN
    , .perf_issue(perf_issue), .perf_stall(perf_stall)
`endif
  );

  function automatic dfp96_t f(input dfp96_t a, input dfp96_t b, input logic op);
    return op ? a - b : a + b;
  endfunction

  // Pipe model: pipe_* seen in T+1, result on pipe_o in T+LAT.
  dfp96_t dl [LAT-1];
  always @(posedge clk) begin
    if (pipe_ce) begin
      dl[0] <= f(pipe_a, pipe_b, pipe_op);
      for (int i = 1; i < LAT - 1; i++) dl[i] <= dl[i-1];
    end
  end
  assign pipe_o = dl[LAT-2];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Operands: requester i gets a=i+1, b=100, add.
  task automatic set_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i*96 +: 96] = 96'(i + 1);
      req_b[i*96 +: 96] = 96'd100;
      req_rm[i*3 +: 3]  = 3'd0;
    end
    req_op = '0;
  endtask

  // Pop responses (rsp_ready held 1 by caller) until n collected or bound hit.
  task automatic collect(input int n, input int bound);
    int c;
    c = 0;
    while (got_id.size() < n && c < bound) begin
      if (rsp_valid) begin
        got_id.push_back(int'(rsp_id));
        got_o.push_back(rsp_o);
      end
      step();
      c++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '1;
    set_ops();
    rsp_ready = 1'b0;
    #3;
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready got %b want 0", req_ready); end
    checks++; if (pipe_ce !== 1'b0) begin errors++; $display("FAIL reset_pipe_ce got %b want 0", pipe_ce); end
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_rsp got v=%b busy=%b want 0", rsp_valid, busy); end
    checks++; if (pipe_a !== '0 || rsp_o !== '0) begin errors++; $display("FAIL reset_data got a=%0h o=%0h want 0", pipe_a, rsp_o); end
    step();
    rst_n = 1'b1;
    #1;
    checks++; if (pipe_ce !== 1'b0) begin errors++; $display("FAIL release_ce got %b want 0", pipe_ce); end
    step();
    checks++; if (pipe_ce !== 1'b1 || req_ready !== 4'b0001) begin errors++; $display("FAIL first_clk got ce=%b ready=%b want 1/0001", pipe_ce, req_ready); end
    req_valid = '0;
  endtask

  task automatic test_single(input int id, input logic op, input logic [2:0] rm,
                             input dfp96_t a, input dfp96_t b, input dfp96_t exp);
    do_reset();
    set_ops();
    req_op[id]           = op;
    req_rm[id*3 +: 3]    = rm;
    req_a[id*96 +: 96]   = a;
    req_b[id*96 +: 96]   = b;
    req_valid            = 4'(1 << id);
    #1;
    checks++; if (req_ready !== 4'(1 << id)) begin errors++; $display("FAIL single_ready got %b want %b", req_ready, 4'(1 << id)); end
    step();
    req_valid = '0;
    checks++; if (pipe_a !== a || pipe_b !== b || pipe_op !== op || pipe_rm !== rm) begin
      errors++; $display("FAIL single_pipe got a=%0h b=%0h op=%b rm=%0d want a=%0h b=%0h op=%b rm=%0d", pipe_a, pipe_b, pipe_op, pipe_rm, a, b, op, rm); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
    for (int i = 0; i < LAT - 1; i++) step();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early got %b want 0", rsp_valid); end
    step();
    checks++; if (rsp_valid !== 1'b1 || int'(rsp_id) != id || rsp_o !== exp) begin
      errors++; $display("FAIL single_rsp got v=%b id=%0d o=%0h want 1/%0d/%0h", rsp_valid, rsp_id, rsp_o, id, exp); end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_drain got v=%b busy=%b want 0/0", rsp_valid, busy); end
  endtask

  task automatic test_round_robin();
    do_reset();
    set_ops();
    rsp_ready = 1'b1;
    req_valid = '1;
    #1;
    for (int k = 0; k < 8; k++) begin
      checks++; if (req_ready !== 4'(1 << (k % 4))) begin errors++; $display("FAIL rr_grant%0d got %b want %b", k, req_ready, 4'(1 << (k % 4))); end
      step();
    end
    req_valid = '0;
    got_id.delete(); got_o.delete();
    collect(8, 60);
    checks++; if (got_id.size() != 8) begin errors++; $display("FAIL rr_count got %0d want 8", got_id.size()); end
    for (int k = 0; k < got_id.size(); k++) begin
      checks++; if (got_id[k] != k % 4 || got_o[k] !== 96'(k % 4 + 101)) begin
        errors++; $display("FAIL rr_rsp%0d got id=%0d o=%0h want %0d/%0h", k, got_id[k], got_o[k], k % 4, k % 4 + 101); end
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int n_hs, n_stall;
    bit resumed;
    do_reset();
    set_ops();
    rsp_ready = 1'b0;
    req_valid = '1;
    n_hs = 0; n_stall = 0;
    #1;
    for (int c = 0; c < 30; c++) begin
      if (req_ready != '0) n_hs++; else n_stall++;
      step();
    end
    checks++; if (n_hs != 8) begin errors++; $display("FAIL bp_issues got %0d want 8", n_hs); end
    checks++; if (req_ready !== '0 || rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_blocked got ready=%b v=%b want 0/1", req_ready, rsp_valid); end
`ifdef DFP_SCHED_PERF_EN
    checks++; if (perf_issue !== 32'd8) begin errors++; $display("FAIL perf_issue got %0d want 8", perf_issue); end
    checks++; if (perf_stall !== 32'(n_stall)) begin errors++; $display("FAIL perf_stall got %0d want %0d", perf_stall, n_stall); end
`endif
    rsp_ready = 1'b1;
    resumed = 1'b0;
    got_id.delete(); got_o.delete();
    for (int c = 0; c < 40 && got_id.size() < 8; c++) begin
      if (rsp_valid) begin got_id.push_back(int'(rsp_id)); got_o.push_back(rsp_o); end
      if (req_ready != '0) resumed = 1'b1;
      step();
    end
    checks++; if (!resumed) begin errors++; $display("FAIL bp_resume got 0 want 1"); end
    checks++; if (got_id.size() != 8) begin errors++; $display("FAIL bp_count got %0d want 8", got_id.size()); end
    for (int k = 0; k < got_id.size(); k++) begin
      checks++; if (got_id[k] != k % 4 || got_o[k] !== 96'(k % 4 + 101)) begin
        errors++; $display("FAIL bp_rsp%0d got id=%0d o=%0h want %0d/%0h", k, got_id[k], got_o[k], k % 4, k % 4 + 101); end
    end
    req_valid = '0;
    for (int c = 0; c < 80 && busy; c++) step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle got %b want 0", busy); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_push_pop();
    bit seen;
    do_reset();
    set_ops();
    rsp_ready = 1'b0;
    req_valid = '1;
    for (int c = 0; c < 8; c++) step();
    req_valid = '0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (dut.fifo_count == 4'd3) seen = 1'b1; else step();
    end
    checks++; if (!seen) begin errors++; $display("FAIL pp_reach3 got timeout want count 3"); end
    rsp_ready = 1'b1;
    got_id.delete(); got_o.delete();
    for (int c = 0; c < 6; c++) begin
      checks++; if (dut.fifo_count !== 4'd3) begin errors++; $display("FAIL pp_count%0d got %0d want 3", c, dut.fifo_count); end
      if (rsp_valid) begin got_id.push_back(int'(rsp_id)); got_o.push_back(rsp_o); end
      step();
    end
    collect(8, 20);
    checks++; if (got_id.size() != 8) begin errors++; $display("FAIL pp_total got %0d want 8", got_id.size()); end
    for (int k = 0; k < got_id.size(); k++) begin
      checks++; if (got_id[k] != k % 4 || got_o[k] !== 96'(k % 4 + 101)) begin
        errors++; $display("FAIL pp_rsp%0d got id=%0d o=%0h want %0d/%0h", k, got_id[k], got_o[k], k % 4, k % 4 + 101); end
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    int n_rsp;
    do_reset();
    set_ops();
    rsp_ready = 1'b1;
    req_valid = '1;
    for (int c = 0; c < 5; c++) step();
    req_valid = '0;
    step(); step(); step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mr_busy got %b want 1", busy); end
    req_valid = '1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || pipe_ce !== 1'b0 || req_ready !== '0 || pipe_a !== '0) begin
      errors++; $display("FAIL mr_async got busy=%b v=%b ce=%b ready=%b a=%0h want all 0", busy, rsp_valid, pipe_ce, req_ready, pipe_a); end
    req_valid = '0;
    step(); step();
    rst_n = 1'b1;
    n_rsp = 0;
    for (int c = 0; c < 30; c++) begin
      if (rsp_valid) n_rsp++;
      step();
    end
    checks++; if (n_rsp != 0) begin errors++; $display("FAIL mr_stale got %0d responses want 0", n_rsp); end
    req_valid = '1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mr_ptr got %b want 0001", req_ready); end
    req_valid = '0;
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_op = '0; req_rm = '0; req_a = '0; req_b = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_single(0, 1'b0, 3'd0, 96'd1, 96'd2, 96'd3);
    test_single(2, 1'b1, 3'd5, 96'd10, 96'd4, 96'd6);
    test_round_robin();
    test_backpressure();
    test_push_pop();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
